// File: rtl/branch_resolver.sv
// Branch resolution unit for the EX stage.
// Computes outcome/target, updates the predictor and drives recovery.
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [31:0]      pc_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    input  logic [31:0]      imm_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_target_i,
    output logic             upd_valid_o,
    output logic [31:0]      upd_pc_o,
    output logic [31:0]      upd_target_o,
    output logic             upd_taken_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        legal;
    logic        taken;
    logic        accept;
    logic        mispredict;
    logic [31:0] target;
    logic [31:0] fallthru;

    // Branch condition evaluation and funct3 legality
    always_comb begin
        legal = 1'b1;
        taken = 1'b0;
        case (funct3_i)
            3'b000: taken = (rs1_i == rs2_i);
            3'b001: taken = (rs1_i != rs2_i);
            3'b100: taken = ($signed(rs1_i) < $signed(rs2_i));
            3'b101: taken = ($signed(rs1_i) >= $signed(rs2_i));
            3'b110: taken = (rs1_i < rs2_i);
            3'b111: taken = (rs1_i >= rs2_i);
            default: legal = 1'b0;
        endcase
    end

    assign target     = pc_i + imm_i;
    assign fallthru   = pc_i + 32'd4;
    assign mispredict = (taken != pred_taken_i) ||
                        (taken && (pred_target_i != target));
    assign accept     = valid_i && (state_q == IDLE) && legal;

    // FSM state and flush down-counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state: a mispredict holds RECOVER for FLUSH_CYCLES cycles
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (accept && mispredict) begin
                    state_d = RECOVER;
                    fcnt_d  = 4'(FLUSH_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (fcnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 4'd0;
            end
        endcase
    end

    // Recovery outputs are decoded from state so reset drops them at once
    always_comb begin
        flush_o = (state_q == RECOVER);
        busy_o  = (state_q == RECOVER);
    end

    // Predictor update and redirect strobes; data holds between strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_valid_o   <= 1'b0;
            upd_pc_o      <= 32'd0;
            upd_target_o  <= 32'd0;
            upd_taken_o   <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= 32'd0;
        end else begin
            upd_valid_o <= accept;
            redirect_o  <= accept && mispredict;
            if (accept) begin
                upd_pc_o     <= pc_i;
                upd_target_o <= target;
                upd_taken_o  <= taken;
            end
            if (accept && mispredict) begin
                redirect_pc_o <= taken ? target : fallthru;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            if (accept && (branch_cnt_o != '1)) begin
                branch_cnt_o <= branch_cnt_o + 1'b1;
            end
            if (accept && mispredict && (mispredict_cnt_o != '1)) begin
                mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver.
// Scoreboard of expected next-cycle outputs, checked per scenario.
module tb_branch_resolver;

    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic [31:0]   pc_i;
    logic [2:0]    funct3_i;
    logic [31:0]   rs1_i;
    logic [31:0]   rs2_i;
    logic [31:0]   imm_i;
    logic          pred_taken_i;
    logic [31:0]   pred_target_i;
    logic          upd_valid_o;
    logic [31:0]   upd_pc_o;
    logic [31:0]   upd_target_o;
    logic          upd_taken_o;
    logic          redirect_o;
    logic [31:0]   redirect_pc_o;
    logic          flush_o;
    logic          busy_o;
    logic [CW-1:0] branch_cnt_o;
    logic [CW-1:0] mispredict_cnt_o;

    branch_resolver #(
        .FLUSH_CYCLES(FC),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .valid_i(valid_i),
        .pc_i(pc_i),
        .funct3_i(funct3_i),
        .rs1_i(rs1_i),
        .rs2_i(rs2_i),
        .imm_i(imm_i),
        .pred_taken_i(pred_taken_i),
        .pred_target_i(pred_target_i),
        .upd_valid_o(upd_valid_o),
        .upd_pc_o(upd_pc_o),
        .upd_target_o(upd_target_o),
        .upd_taken_o(upd_taken_o),
        .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o),
        .busy_o(busy_o),
        .branch_cnt_o(branch_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          uv;
        logic [31:0]   upc;
        logic [31:0]   utg;
        logic          utk;
        logic          rd;
        logic [31:0]   rpc;
        logic          fl;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    exp_t e;
    int   m_rem;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic ref_taken(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        logic t;
        t = 1'b0;
        case (f)
            3'b000: t = (a == b);
            3'b001: t = (a != b);
            3'b100: t = ($signed(a) < $signed(b));
            3'b101: t = ($signed(a) >= $signed(b));
            3'b110: t = (a < b);
            3'b111: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    task automatic model_reset();
        m.uv  = 1'b0;
        m.upc = '0;
        m.utg = '0;
        m.utk = 1'b0;
        m.rd  = 1'b0;
        m.rpc = '0;
        m.fl  = 1'b0;
        m.bc  = '0;
        m.mc  = '0;
        m_rem = 0;
        sb.delete();
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs
    task automatic drive_br(input logic v, input logic [2:0] f,
                            input logic [31:0] pc,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [31:0] imm,
                            input logic pt,
                            input logic [31:0] ptg);
        logic        tk;
        logic        lg;
        logic        mis;
        logic [31:0] tg;
        valid_i       = v;
        funct3_i      = f;
        pc_i          = pc;
        rs1_i         = a;
        rs2_i         = b;
        imm_i         = imm;
        pred_taken_i  = pt;
        pred_target_i = ptg;
        lg  = !(f == 3'b010 || f == 3'b011);
        tk  = ref_taken(f, a, b);
        tg  = pc + imm;
        mis = (tk != pt) || (tk && ptg != tg);
        m.uv = 1'b0;
        m.rd = 1'b0;
        if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end else if (v && lg) begin
            m.uv  = 1'b1;
            m.upc = pc;
            m.utg = tg;
            m.utk = tk;
            if (m.bc != '1) m.bc = m.bc + 1'b1;
            if (mis) begin
                m.rd  = 1'b1;
                m.rpc = tk ? tg : pc + 32'd4;
                m_rem = FC;
                if (m.mc != '1) m.mc = m.mc + 1'b1;
            end
        end
        m.fl = (m_rem > 0);
        sb.push_back(m);
    endtask

    task automatic idle();
        drive_br(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        sb.delete();
        rst_i = 1'b1;
        model_reset();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        #3;
        n_chk++;
        if ({upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o,
             redirect_o, redirect_pc_o, flush_o, busy_o,
             branch_cnt_o, mispredict_cnt_o} !== '0)
            $display("FAIL reset_outs: uv=%0b rd=%0b fl=%0b bc=%0h want 0",
                     upd_valid_o, redirect_o, flush_o, branch_cnt_o);
        else n_pass++;
        model_reset();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_beq_correct();
        do_reset();
        drive_br(1'b1, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20,
                 1'b1, 32'h120);
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({upd_valid_o, upd_taken_o, upd_target_o, upd_pc_o} !==
            {e.uv, e.utk, e.utg, e.upc})
            $display("FAIL beq_upd: v=%0b t=%0b tg=%h want %0b %0b %h",
                     upd_valid_o, upd_taken_o, upd_target_o,
                     e.uv, e.utk, e.utg);
        else n_pass++;
        n_chk++;
        if ({redirect_o, flush_o, busy_o} !== 3'b000)
            $display("FAIL beq_norecov: rd=%0b fl=%0b bz=%0b want 0",
                     redirect_o, flush_o, busy_o);
        else n_pass++;
        n_chk++;
        if (branch_cnt_o !== e.bc)
            $display("FAIL beq_bcnt: got %0d want %0d",
                     branch_cnt_o, e.bc);
        else n_pass++;
        idle();
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({upd_valid_o, upd_target_o, upd_pc_o} !==
            {1'b0, e.utg, e.upc})
            $display("FAIL hold_upd: v=%0b tg=%h want 0 %h",
                     upd_valid_o, upd_target_o, e.utg);
        else n_pass++;
    endtask

    task automatic test_blt_mispredict();
        do_reset();
        drive_br(1'b1, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40,
                 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            e = sb.pop_front();
            n_chk++;
            if ({redirect_o, flush_o, busy_o} !== {e.rd, e.fl, e.fl})
                $display("FAIL blt_cyc%0d: rd=%0b fl=%0b bz=%0b want %0b %0b",
                         i, redirect_o, flush_o, busy_o, e.rd, e.fl);
            else n_pass++;
            if (i == 0) begin
                n_chk++;
                if ({redirect_pc_o, upd_taken_o, mispredict_cnt_o} !==
                    {e.rpc, e.utk, e.mc})
                    $display("FAIL blt_rpc: pc=%h tk=%0b mc=%0d want %h %0b %0d",
                             redirect_pc_o, upd_taken_o, mispredict_cnt_o,
                             e.rpc, e.utk, e.mc);
                else n_pass++;
            end
            idle();
        end
        tick();
        void'(sb.pop_front());
    endtask

    task automatic test_bltu();
        do_reset();
        drive_br(1'b1, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40,
                 1'b1, 32'h240);
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({redirect_o, redirect_pc_o, upd_taken_o} !==
            {e.rd, e.rpc, e.utk})
            $display("FAIL bltu: rd=%0b pc=%h tk=%0b want %0b %h %0b",
                     redirect_o, redirect_pc_o, upd_taken_o,
                     e.rd, e.rpc, e.utk);
        else n_pass++;
        for (int i = 0; i < FC; i++) begin
            idle();
            tick();
            void'(sb.pop_front());
        end
    endtask

    task automatic test_wrong_path();
        logic [CW-1:0] b0;
        do_reset();
        b0 = m.bc;
        drive_br(1'b1, 3'b001, 32'h400, 32'd1, 32'd2, 32'h10,
                 1'b0, 32'h0);
        tick();
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_br(1'b1, 3'b000, 32'h500 + 32'(i * 4), 32'd7, 32'd7,
                     32'h8, 1'b1, 32'h508 + 32'(i * 4));
            tick();
            e = sb.pop_front();
            n_chk++;
            if ({upd_valid_o, redirect_o, flush_o} !== {e.uv, e.rd, e.fl})
                $display("FAIL wrongpath%0d: uv=%0b rd=%0b fl=%0b want %0b %0b %0b",
                         i, upd_valid_o, redirect_o, flush_o,
                         e.uv, e.rd, e.fl);
            else n_pass++;
        end
        n_chk++;
        if (branch_cnt_o !== CW'(b0 + 2))
            $display("FAIL wrongpath_bcnt: got %0d want %0d",
                     branch_cnt_o, b0 + 2);
        else n_pass++;
        idle();
        tick();
        void'(sb.pop_front());
    endtask

    task automatic test_target_wrap();
        do_reset();
        drive_br(1'b1, 3'b000, 32'h100, 32'd3, 32'd3, 32'h20,
                 1'b1, 32'h300);
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({redirect_o, redirect_pc_o} !== {e.rd, e.rpc})
            $display("FAIL tgt_mismatch: rd=%0b pc=%h want %0b %h",
                     redirect_o, redirect_pc_o, e.rd, e.rpc);
        else n_pass++;
        for (int i = 0; i < FC; i++) begin
            idle();
            tick();
            void'(sb.pop_front());
        end
        drive_br(1'b1, 3'b111, 32'hFFFF_FFFC, 32'd9, 32'd2, 32'd4,
                 1'b1, 32'h0);
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({upd_valid_o, upd_target_o, redirect_o} !==
            {e.uv, e.utg, e.rd})
            $display("FAIL wrap: uv=%0b tg=%h rd=%0b want %0b %h %0b",
                     upd_valid_o, upd_target_o, redirect_o,
                     e.uv, e.utg, e.rd);
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        drive_br(1'b1, 3'b010, 32'h600, 32'd1, 32'd2, 32'h10,
                 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        drive_br(1'b1, 3'b011, 32'h604, 32'd1, 32'd1, 32'h10,
                 1'b1, 32'h0);
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({upd_valid_o, redirect_o, flush_o, branch_cnt_o,
             mispredict_cnt_o} !== {e.uv, e.rd, e.fl, e.bc, e.mc})
            $display("FAIL illegal: uv=%0b rd=%0b bc=%0d want %0b %0b %0d",
                     upd_valid_o, redirect_o, branch_cnt_o,
                     e.uv, e.rd, e.bc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        tk;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 5))
                0: f = 3'b000;
                1: f = 3'b001;
                2: f = 3'b100;
                3: f = 3'b101;
                4: f = 3'b110;
                default: f = 3'b111;
            endcase
            a   = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : $urandom;
            b   = $urandom_range(0, 2) == 0 ? a : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = $urandom & 32'h0000_1FFE;
            tk  = ref_taken(f, a, b);
            drive_br(1'b1, f, pc, a, b, imm, tk, pc + imm);
            tick();
            e = sb.pop_front();
            n_chk++;
            if ({upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o,
                 redirect_o, flush_o} !==
                {e.uv, e.upc, e.utg, e.utk, e.rd, e.fl})
                $display("FAIL b2b%0d: uv=%0b tg=%h tk=%0b rd=%0b want %0b %h %0b %0b",
                         i, upd_valid_o, upd_target_o, upd_taken_o,
                         redirect_o, e.uv, e.utg, e.utk, e.rd);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_br(1'b1, 3'b000, 32'h700, 32'd1, 32'd2, 32'h8,
                     1'b0, 32'h0);
            tick();
            void'(sb.pop_front());
        end
        n_chk++;
        if (branch_cnt_o !== 4'hF)
            $display("FAIL sat_bcnt: got %0h want f", branch_cnt_o);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            drive_br(1'b1, 3'b000, 32'h800, 32'd1, 32'd1, 32'h8,
                     1'b0, 32'h0);
            tick();
            void'(sb.pop_front());
            for (int j = 0; j < FC; j++) begin
                idle();
                tick();
                void'(sb.pop_front());
            end
        end
        n_chk++;
        if ({branch_cnt_o, mispredict_cnt_o} !== 8'hFF)
            $display("FAIL sat_mcnt: bc=%0h mc=%0h want f f",
                     branch_cnt_o, mispredict_cnt_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive_br(1'b1, 3'b001, 32'h900, 32'd4, 32'd5, 32'h40,
                 1'b0, 32'h0);
        tick();
        e = sb.pop_front();
        n_chk++;
        if (flush_o !== e.fl)
            $display("FAIL midflush_pre: fl=%0b want %0b", flush_o, e.fl);
        else n_pass++;
        idle();
        sb.delete();
        #1;
        rst_i = 1'b1;
        #1;
        n_chk++;
        if ({upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o,
             redirect_o, redirect_pc_o, flush_o, busy_o,
             branch_cnt_o, mispredict_cnt_o} !== '0)
            $display("FAIL midflush_rst: fl=%0b bz=%0b rd=%0b bc=%0d want 0",
                     flush_o, busy_o, redirect_o, branch_cnt_o);
        else n_pass++;
        model_reset();
        tick();
        rst_i = 1'b0;
        drive_br(1'b1, 3'b000, 32'hA00, 32'd6, 32'd6, 32'h10,
                 1'b1, 32'hA10);
        tick();
        e = sb.pop_front();
        n_chk++;
        if ({upd_valid_o, upd_target_o, flush_o, branch_cnt_o} !==
            {e.uv, e.utg, e.fl, e.bc})
            $display("FAIL post_rst: uv=%0b tg=%h fl=%0b want %0b %h %0b",
                     upd_valid_o, upd_target_o, flush_o,
                     e.uv, e.utg, e.fl);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        model_reset();
        idle();
        sb.delete();
        test_reset();
        test_beq_correct();
        test_blt_mispredict();
        test_bltu();
        test_wrong_path();
        test_target_wrap();
        test_illegal();
        test_back_to_back();
        test_saturate();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush_o is held after a mispredict (legal range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  a conditional branch is present in EX this cycle.
REQ-006 pc_i  input  32  PC of the branch.
REQ-007 funct3_i  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-008 rs1_i, rs2_i  input  32 each  operand values.
REQ-009 imm_i  input  32  sign-extended B-type offset.
REQ-010 pred_taken_i  input  1  fetch-stage prediction carried with the branch.
REQ-011 pred_target_i  input  32  fetch-stage predicted target.
REQ-012 upd_valid_o  output  1  one-cycle predictor update strobe.
REQ-013 upd_pc_o, upd_target_o  output  32 each  branch PC and computed target for the predictor.
REQ-014 upd_taken_o  output  1  actual outcome.
REQ-015 redirect_o  output  1  one-cycle fetch redirect strobe.
REQ-016 redirect_pc_o  output  32  corrected fetch address.
REQ-017 flush_o  output  1  squash younger pipeline stages.
REQ-018 busy_o  output  1  recovery in progress; valid_i is ignored.
REQ-019 branch_cnt_o, mispredict_cnt_o  output  CNT_W each  saturating counts.

Function
REQ-020 Outcome: taken = rs1==rs2 (BEQ), != (BNE), signed < (BLT), signed >= (BGE), unsigned < (BLTU), unsigned >= (BGEU).
REQ-021 target = pc_i + imm_i modulo 2^32; fallthrough = pc_i + 4 modulo 2^32.
REQ-022 Mispredict = (taken != pred_taken_i) OR (taken AND pred_target_i != target).
REQ-023 Corrected PC = target if taken, else fallthrough.
REQ-024 FSM states: IDLE, RECOVER; a 4-bit down-counter tracks the remaining flush cycles.
REQ-025 A branch is accepted only when valid_i=1, state=IDLE and funct3_i is legal.
REQ-026 On an accepted branch in cycle N, in cycle N+1 (registered, latency 1):
- upd_valid_o=1 for exactly one cycle.
- upd_pc_o=pc_i, upd_target_o=target, upd_taken_o=taken.
- branch_cnt_o increments.
REQ-027 If the accepted branch mispredicts:
- In cycle N+1: redirect_o=1 for one cycle and redirect_pc_o = corrected PC.
- The FSM enters RECOVER.
- flush_o=1 and busy_o=1 for cycles N+1 .. N+FLUSH_CYCLES.
- mispredict_cnt_o increments in cycle N+1.
REQ-028 When the counter expires, RECOVER SHALL return to IDLE; a valid_i in cycle N+FLUSH_CYCLES+1 SHALL be accepted.
REQ-029 valid_i while in RECOVER is wrong-path: no update, no counting, no redirect, no extension of the flush.
REQ-030 A correctly predicted branch SHALL cause no redirect and no flush, and the FSM stays in IDLE.
REQ-031 Back-to-back correct branches SHALL be accepted every cycle.
REQ-032 Illegal funct3 (010, 011) with valid_i=1: no update, no redirect, no counter change.
REQ-033 Both counters saturate at all-ones and never wrap.
REQ-034 When no strobe is active, upd_* and redirect_pc_o data outputs SHALL hold their last values.

Reset
REQ-035 While rst_i=1, all outputs SHALL be 0, the FSM SHALL be in IDLE, and both counters and the flush counter SHALL be 0, regardless of clock.
REQ-036 An assertion of rst_i during RECOVER SHALL immediately drop flush_o and busy_o; the first edge after release SHALL operate from IDLE.

Verification
REQ-037 BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> upd_valid, upd_taken=1, upd_target=0x120 next cycle; no redirect or flush; branch_cnt=1.
REQ-038 BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred_taken=0 -> taken; redirect_pc=0x240; flush_o high 2 cycles; mispredict_cnt=1.
REQ-039 BLTU with the same operands, pred_taken=1, pred_target=0x240 -> not taken; redirect_pc=0x204.
REQ-040 Mispredict followed by valid_i on each of the next 3 cycles -> the first 2 are ignored, the 3rd is accepted; branch_cnt rises by 2 in total.
REQ-041 Taken branch with pred_taken=1 and pred_target=0x300 against an actual target of 0x120 -> mispredict; redirect_pc=0x120; pc=0xFFFFFFFC with imm=4 -> target wraps to 0x0.
REQ-042 Force the counters to saturate (CNT_W=4, 20 branches) -> the counters hold at 0xF; assert rst_i mid-flush -> all outputs 0 asynchronously.
